// File: rtl/fm_result_arbiter.sv
// fm_result_arbiter: buffers per-channel capture results and serialises them round-robin onto one RAM write port
module fm_result_arbiter #(
  parameter int INPUTS_COUNT = 24,
  parameter int CNT_WIDTH    = 30,
  parameter int ADDR_WIDTH   = 5
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [INPUTS_COUNT-1:0]           chan_enable_i,
  input  logic [INPUTS_COUNT-1:0]           cap_valid_i,
  input  logic [INPUTS_COUNT*CNT_WIDTH-1:0] cap_data_i,
  output logic                              wr_valid_o,
  input  logic                              wr_ready_i,
  output logic [ADDR_WIDTH-1:0]             wr_addr_o,
  output logic [CNT_WIDTH-1:0]              wr_data_o,
  output logic [INPUTS_COUNT-1:0]           ovf_o,
  input  logic [INPUTS_COUNT-1:0]           ovf_clr_i,
  output logic                              done_o,
  output logic [ADDR_WIDTH-1:0]             done_chan_o
);
  typedef enum logic {IDLE, OFFER} state_t;
  state_t state, state_n;
  logic [CNT_WIDTH-1:0] hold [INPUTS_COUNT];
  logic [INPUTS_COUNT-1:0] pending, cap, elig, gmask, ovf_set;
  logic [ADDR_WIDTH-1:0] ptr, next_g, base, gsel;
  logic xfer, found, grant;
  always_comb begin
    cap = cap_valid_i & chan_enable_i;
    elig = pending & chan_enable_i;
    xfer = (state == OFFER) && wr_ready_i;
    next_g = (wr_addr_o == ADDR_WIDTH'(INPUTS_COUNT - 1)) ? '0 : wr_addr_o + ADDR_WIDTH'(1);
    base = (state == OFFER) ? next_g : ptr;
    found = 1'b0;
    gsel = '0;
    for (int i = 0; i < INPUTS_COUNT; i++) begin
      if (!found && elig[(int'(base) + i) % INPUTS_COUNT]) begin
        found = 1'b1;
        gsel = ADDR_WIDTH'((int'(base) + i) % INPUTS_COUNT);
      end
    end
    grant = found && ((state == IDLE) || xfer);
    gmask = grant ? (INPUTS_COUNT'(1) << gsel) : '0;
    ovf_set = cap & pending & ~gmask;
    state_n = grant ? OFFER : xfer ? IDLE : state;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      ptr <= '0;
      pending <= '0;
      ovf_o <= '0;
      wr_addr_o <= '0;
      wr_data_o <= '0;
      done_o <= 1'b0;
      done_chan_o <= '0;
    end else begin
      state <= state_n;
      ptr <= xfer ? next_g : ptr;
      pending <= ((pending & ~gmask) | cap) & chan_enable_i;
      ovf_o <= (ovf_o & ~ovf_clr_i) | ovf_set;
      wr_addr_o <= grant ? gsel : wr_addr_o;
      wr_data_o <= grant ? hold[gsel] : wr_data_o;
      done_o <= xfer;
      done_chan_o <= xfer ? wr_addr_o : done_chan_o;
    end
  end
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < INPUTS_COUNT; k++)
      if (cap[k]) hold[k] <= cap_data_i[k*CNT_WIDTH +: CNT_WIDTH];
  end
  assign wr_valid_o = (state == OFFER);
endmodule

// File: tb/tb_fm_result_arbiter.sv
// tb_fm_result_arbiter: directed scoreboard bench for fm_result_arbiter
module tb_fm_result_arbiter;
  localparam int N = 24;
  localparam int W = 30;
  localparam int A = 5;
  logic clk = 0;
  logic rst_i;
  logic [N-1:0] chan_enable_i, cap_valid_i, ovf_clr_i, ovf_o;
  logic [N*W-1:0] cap_data_i;
  logic wr_valid_o, wr_ready_i, done_o;
  logic [A-1:0] wr_addr_o, done_chan_o;
  logic [W-1:0] wr_data_o;
  typedef struct packed {logic [A-1:0] a; logic [W-1:0] d;} exp_t;
  exp_t sb[$];
  exp_t e_m;
  int errs = 0, checks = 0;
  logic mon_on = 0, prev_x = 0;
  logic [A-1:0] prev_a = '0;
  fm_result_arbiter #(.INPUTS_COUNT(N), .CNT_WIDTH(W), .ADDR_WIDTH(A)) dut (
    .clk_i(clk), .rst_i(rst_i), .chan_enable_i(chan_enable_i), .cap_valid_i(cap_valid_i),
    .cap_data_i(cap_data_i), .wr_valid_o(wr_valid_o), .wr_ready_i(wr_ready_i),
    .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o), .ovf_o(ovf_o), .ovf_clr_i(ovf_clr_i),
    .done_o(done_o), .done_chan_o(done_chan_o)
  );
  always #5 clk = ~clk;
  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
      cap_valid_i = '0;
      ovf_clr_i = '0;
    end
  endtask
  task automatic set_cap(int ch, logic [W-1:0] d);
    cap_valid_i[ch] = 1'b1;
    cap_data_i[ch*W +: W] = d;
  endtask
  task automatic push(int ch, logic [W-1:0] d);
    sb.push_back('{a: A'(ch), d: d});
  endtask
  always @(negedge clk) begin
    if (mon_on) begin
      chk("done", done_o, prev_x);
      if (prev_x) chk("done_chan", done_chan_o, prev_a);
    end
    prev_x = wr_valid_o & wr_ready_i & ~rst_i;
    prev_a = wr_addr_o;
    if (mon_on && prev_x) begin
      chk("write_expected", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e_m = sb.pop_front();
        chk("wr_addr", wr_addr_o, e_m.a);
        chk("wr_data", wr_data_o, e_m.d);
      end
    end
  end
  initial begin
    rst_i = 1; chan_enable_i = '1; cap_valid_i = '0; cap_data_i = '0; ovf_clr_i = '0; wr_ready_i = 1;
    tick(2);
    rst_i = 0;
    @(negedge clk);
    chk("rst_valid", wr_valid_o, 0);
    chk("rst_addr", wr_addr_o, 0);
    chk("rst_data", wr_data_o, 0);
    chk("rst_ovf", ovf_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_done_chan", done_chan_o, 0);
    mon_on = 1;
    tick();
    // single capture and its latency
    set_cap(5, 30'h1234567); push(5, 30'h1234567);
    tick();
    chk("lat_pend_no_valid", wr_valid_o, 0);
    tick();
    chk("lat_valid", wr_valid_o, 1);
    chk("lat_addr", wr_addr_o, 5);
    tick(3);
    chk("single_ovf", ovf_o, 0);
    // round robin from a fresh pointer
    rst_i = 1; tick(); rst_i = 0; tick();
    set_cap(3, 30'h33); set_cap(7, 30'h77); set_cap(20, 30'h2020);
    push(3, 30'h33); push(7, 30'h77); push(20, 30'h2020);
    tick(2);
    chk("rr_first", wr_addr_o, 3);
    tick();
    chk("rr_second", wr_addr_o, 7);
    chk("rr_b2b_valid", wr_valid_o, 1);
    tick();
    chk("rr_third", wr_addr_o, 20);
    tick(3);
    set_cap(3, 30'h303); set_cap(7, 30'h707);
    push(3, 30'h303); push(7, 30'h707);
    tick(2);
    chk("rr_wrap_first", wr_addr_o, 3);
    tick();
    chk("rr_wrap_second", wr_addr_o, 7);
    tick(3);
    // backpressure with a recapture during the hold
    wr_ready_i = 0;
    set_cap(2, 30'h55); push(2, 30'h55); push(2, 30'hAA);
    tick(2);
    for (int i = 0; i < 10; i++) begin
      if (i == 4) set_cap(2, 30'hAA);
      tick();
      chk("bp_valid", wr_valid_o, 1);
      chk("bp_addr", wr_addr_o, 2);
      chk("bp_data", wr_data_o, 30'h55);
    end
    chk("bp_no_ovf", ovf_o[2], 0);
    wr_ready_i = 1;
    tick();
    chk("bp_second_addr", wr_addr_o, 2);
    chk("bp_second_data", wr_data_o, 30'hAA);
    tick(3);
    // overrun behind a stalled channel
    wr_ready_i = 0;
    set_cap(8, 30'h80); push(8, 30'h80); push(9, 30'h22);
    tick(2);
    set_cap(9, 30'h11); tick();
    chk("ovf_not_yet", ovf_o[9], 0);
    set_cap(9, 30'h22); tick();
    chk("ovf_set", ovf_o[9], 1);
    wr_ready_i = 1;
    tick(4);
    ovf_clr_i[9] = 1; tick();
    chk("ovf_cleared", ovf_o[9], 0);
    wr_ready_i = 0;
    set_cap(8, 30'h81); push(8, 30'h81); push(9, 30'h44);
    tick(2);
    set_cap(9, 30'h33); tick();
    set_cap(9, 30'h44); ovf_clr_i[9] = 1; tick();
    chk("ovf_set_wins", ovf_o[9], 1);
    wr_ready_i = 1;
    tick(4);
    ovf_clr_i[9] = 1; tick();
    chk("ovf_all_clear", ovf_o, 0);
    // enable mask
    chan_enable_i[4] = 0;
    set_cap(4, 30'h44);
    tick(3);
    chk("mask_no_write", wr_valid_o, 0);
    chan_enable_i[4] = 1;
    wr_ready_i = 0;
    set_cap(10, 30'hA); set_cap(11, 30'hB); push(10, 30'hA);
    tick(2);
    chk("dis_offer", wr_addr_o, 10);
    chan_enable_i[11] = 0; tick();
    chan_enable_i[11] = 1; wr_ready_i = 1;
    tick(4);
    chk("dis_idle", wr_valid_o, 0);
    // reset while offering
    wr_ready_i = 0;
    set_cap(1, 30'h1);
    tick(2);
    chk("rst_mid_valid_before", wr_valid_o, 1);
    rst_i = 1; tick(); rst_i = 0;
    chk("rst_mid_valid", wr_valid_o, 0);
    chk("rst_mid_addr", wr_addr_o, 0);
    chk("rst_mid_data", wr_data_o, 0);
    chk("rst_mid_done", done_o, 0);
    chk("rst_mid_done_chan", done_chan_o, 0);
    wr_ready_i = 1;
    set_cap(0, 30'h77); set_cap(1, 30'h78);
    push(0, 30'h77); push(1, 30'h78);
    tick(2);
    chk("resume_first", wr_addr_o, 0);
    for (int i = 0; i < 50 && sb.size() != 0; i++) tick();
    tick(2);
    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/fm_result_arbiter.md
# fm_result_arbiter

Round-robin scheduler that gathers capture results from the `F_INPUTS_COUNT` per-channel frequency counters and serialises them onto the single shared result-memory write port. It sits between the counter array driven by `Fin` and the result RAM read by the CPU. It buffers one result per channel, flags lost results, and issues a completion pulse per stored result for interrupt logic.

## Interface
- `INPUTS_COUNT`, default 24: number of measurement channels (1..32).
- `CNT_WIDTH`, default 30: width of one captured value.
- `ADDR_WIDTH`, default 5: result address width; `2**ADDR_WIDTH >= INPUTS_COUNT`.

Ports:
- `clk_i` in 1: system clock. One clock; reset is synchronous and active-high.
- `rst_i` in 1: synchronous reset, active-high.
- `chan_enable_i` in INPUTS_COUNT: per-channel enable mask.
- `cap_valid_i` in INPUTS_COUNT: one-cycle pulse when channel k has a new capture.
- `cap_data_i` in INPUTS_COUNT*CNT_WIDTH: capture values; channel k at bits [k*CNT_WIDTH +: CNT_WIDTH]. Valid only in the `cap_valid_i[k]` cycle.
- `wr_valid_o` out 1: write request to result RAM.
- `wr_ready_i` in 1: RAM port accepts. A transfer occurs when `wr_valid_o & wr_ready_i`.
- `wr_addr_o` out ADDR_WIDTH: channel index of the offered result.
- `wr_data_o` out CNT_WIDTH: offered value.
- `ovf_o` out INPUTS_COUNT: sticky per-channel overrun flags.
- `ovf_clr_i` in INPUTS_COUNT: write-1-to-clear for `ovf_o`.
- `done_o` out 1: one-cycle pulse, registered after each transfer.
- `done_chan_o` out ADDR_WIDTH: channel of the last transfer; holds its value between pulses.

## Operation
**Per-channel buffer.** Each channel has a holding register `hold[k]` and a `pending[k]` bit.
- A capture is `cap_valid_i[k] & chan_enable_i[k]`. On a capture, `hold[k]` loads the channel's slice and `pending[k]` sets to 1.
- Overrun: a capture while `pending[k]=1`, and channel k is not granted this cycle, sets `ovf[k]`. The newest value overwrites `hold[k]`.
- `cap_valid_i[k]` with `chan_enable_i[k]=0` is ignored.
- `chan_enable_i[k]=0` clears `pending[k]`. A result already in the output register still completes.
- `ovf_clr_i[k]` clears `ovf[k]`. If an overrun and a clear hit the same cycle, the set wins.

**Arbiter FSM**, states IDLE and OFFER.
- IDLE: if any `pending` is set, grant channel g and go to OFFER; otherwise stay in IDLE. g is the lowest index at or above `ptr`, wrapping to 0.
- Grant actions:
  - `wr_addr_o <= g`, `wr_data_o <= hold[g]`, `wr_valid_o <= 1`.
  - Clear `pending[g]`, unless a capture for g occurs in the same cycle; then `pending[g]` stays 1, `hold[g]` takes the new value, and no overrun is flagged.
- OFFER: `wr_valid_o`, `wr_addr_o` and `wr_data_o` hold stable while `wr_ready_i=0`.
- On a transfer, `ptr <= (g+1) mod INPUTS_COUNT`. Then:
  - if another channel is pending in the same cycle, grant it immediately and stay in OFFER (back-to-back, one result per cycle);
  - otherwise drop `wr_valid_o` and go to IDLE.
- The round-robin scan for the back-to-back grant starts at g+1, i.e. the new `ptr`.
- On every transfer, `done_o` pulses on the next cycle and `done_chan_o <= g`.

**Reset** (`rst_i=1` at a clock edge): state=IDLE, `ptr`=0, all `pending`=0, all `ovf_o`=0, `wr_valid_o`=0, `wr_addr_o`=0, `wr_data_o`=0, `done_o`=0, `done_chan_o`=0.
- Reset overrides all captures in the same cycle.
- Reset mid-OFFER drops the offered result without a transfer or `done_o`.
- `hold` contents need no reset.

## Timing
- Latency: capture at edge E0 → `pending` set after E0 → grant at E1 → `wr_valid_o` high after E1 (2 cycles from the capture edge).
- `done_o` is high for the single cycle after the transfer edge.
- Throughput: 1 result/cycle while `wr_ready_i=1` and results are pending. After returning to IDLE, the next grant takes 1 cycle.
- Fairness: worst-case wait for a pending channel is INPUTS_COUNT transfers.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Single capture: ch5, `cap_data`=0x1234567, `wr_ready_i`=1 → `wr_valid_o` 2 cycles later with addr 5, data 0x1234567; `done_o` pulses next cycle with `done_chan_o`=5; `ovf_o`=0.
- Round-robin: ch 3, 7 and 20 capture in the same cycle, ready=1 → writes in order 3, 7, 20 on consecutive cycles. Then ch 3 and 7 capture together (ptr=21) → order 3, 7.
- Backpressure: ch2 offered with ready=0 for 10 cycles → addr/data stable, no `done_o`. Ch2 recaptures 0xAA during the hold → no overflow. After ready rises, a second write of ch2 with 0xAA follows.
- Overrun: ch9 captures 0x11, then 0x22 while still pending behind a stalled ch8 → `ovf_o[9]`=1 and the ch9 write carries 0x22. `ovf_clr_i[9]` pulse → 0. Clear coincident with a new overrun → stays 1.
- Enable mask: `chan_enable_i[4]`=0 with a ch4 capture → no write. Disabling a pending channel → its write never occurs.
- Reset mid-OFFER: `rst_i` while ch1 is offered with ready=0 → the next cycle shows all outputs 0 and no `done_o`. A subsequent ch0 capture resumes normally from `ptr`=0.
